// File: rtl/rpn_pkg.sv
// Shared types for the RPN stack calculator: mode switch, gating FSM states and decoded ops.
package rpn_pkg;

  typedef enum logic [1:0] {
    MODE_STACK,
    MODE_ARITH,
    MODE_LOGIC,
    MODE_SHIFT
  } mode_e;

  typedef enum logic {
    READY,
    HOLD
  } state_e;

  typedef enum logic [3:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_SHL,
    OP_SHR,
    OP_CLR,
    OP_ACK
  } op_e;

  // Lowest-index press wins; key[0]/key[1] meaning depends on the mode switch.
  function automatic op_e decode_op(input logic [3:0] press, input mode_e mode);
    op_e op;
    op = OP_NONE;
    if (press[0]) begin
      case (mode)
        MODE_STACK: op = OP_PUSH;
        MODE_ARITH: op = OP_ADD;
        MODE_LOGIC: op = OP_AND;
        default:    op = OP_SHL;
      endcase
    end else if (press[1]) begin
      case (mode)
        MODE_STACK: op = OP_POP;
        MODE_ARITH: op = OP_SUB;
        MODE_LOGIC: op = OP_OR;
        default:    op = OP_SHR;
      endcase
    end else if (press[2]) begin
      op = OP_CLR;
    end else if (press[3]) begin
      op = OP_ACK;
    end
    return op;
  endfunction

endpackage

// File: rtl/rpn_stack_calc_stack.sv
// DEPTH x WIDTH register stack with occupancy counter; push/pop/replace2/clear commands.
module rpn_stack
  import rpn_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_replace2,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_top,
  output logic [WIDTH-1:0] o_next,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_count;
  logic [AW-1:0]    w_top_idx;
  logic [AW-1:0]    w_next_idx;
  logic [AW-1:0]    w_wr_idx;
  logic             w_do_push;
  logic             w_do_rep;

  assign o_full     = (r_count == CW'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign w_top_idx  = AW'(r_count - CW'(1));
  assign w_next_idx = AW'(r_count - CW'(2));
  assign w_do_push  = i_push & ~o_full & ~i_clear;
  assign w_do_rep   = i_replace2 & (r_count >= CW'(2)) & ~i_clear;
  assign w_wr_idx   = w_do_push ? AW'(r_count) : w_next_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (w_do_push) begin
      r_count <= r_count + CW'(1);
    end else if ((i_pop && !o_empty) || w_do_rep) begin
      r_count <= r_count - CW'(1);
    end
  end

  // Storage is not reset; stale entries are masked by the counter.
  always_ff @(posedge clk) begin
    if (!rst && (w_do_push || w_do_rep)) begin
      r_mem[w_wr_idx] <= i_data;
    end
  end

  assign o_top   = o_empty ? '0 : r_mem[w_top_idx];
  assign o_next  = (r_count < CW'(2)) ? '0 : r_mem[w_next_idx];
  assign o_count = r_count;

endmodule

// File: rtl/rpn_stack_calc.sv
// RPN calculator core: press-edge detection, press/release gating FSM, ALU and sticky flags.
module rpn_stack_calc
  import rpn_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [3:0]       key,
  input  logic [WIDTH-1:0] val,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] next,
  output logic [CW-1:0]    counter,
  output logic             ovf,
  output logic             unf
);

  state_e           r_state, w_state_d;
  logic [3:0]       r_key_q;
  logic             r_ovf, r_unf;
  logic             w_ovf_d, w_unf_d;
  logic [3:0]       w_press;
  op_e              w_op;
  logic [WIDTH-1:0] w_alu;
  logic [WIDTH-1:0] w_wdata;
  logic             w_push, w_pop, w_rep, w_clr;
  logic [WIDTH-1:0] w_top, w_next;
  logic [CW-1:0]    w_count;
  logic             w_full, w_empty;
  logic             w_big_shift;

  assign w_press     = r_key_q & ~key;
  assign w_op        = (r_state == READY) ? decode_op(w_press, mode_e'(mode)) : OP_NONE;
  assign w_big_shift = (w_top >= WIDTH'(WIDTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= READY;
      r_key_q <= 4'hF;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_key_q <= key;
      r_ovf   <= w_ovf_d;
      r_unf   <= w_unf_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      READY:   if (w_press != 4'h0) w_state_d = HOLD;
      HOLD:    if (key == 4'hF) w_state_d = READY;
      default: w_state_d = READY;
    endcase
  end

  always_comb begin
    w_alu = '0;
    case (w_op)
      OP_ADD:  w_alu = w_next + w_top;
      OP_SUB:  w_alu = w_next - w_top;
      OP_AND:  w_alu = w_next & w_top;
      OP_OR:   w_alu = w_next | w_top;
      OP_SHL:  w_alu = w_big_shift ? '0 : (w_next << w_top);
      OP_SHR:  w_alu = w_big_shift ? '0 : (w_next >> w_top);
      default: w_alu = '0;
    endcase
  end

  // Failed ops leave the stack alone and only raise the sticky flag.
  always_comb begin
    w_push  = 1'b0;
    w_pop   = 1'b0;
    w_rep   = 1'b0;
    w_clr   = 1'b0;
    w_wdata = w_alu;
    w_ovf_d = r_ovf;
    w_unf_d = r_unf;
    unique case (w_op)
      OP_PUSH: begin
        w_wdata = val;
        if (w_full) w_ovf_d = 1'b1;
        else        w_push  = 1'b1;
      end
      OP_POP: begin
        if (w_empty) w_unf_d = 1'b1;
        else         w_pop   = 1'b1;
      end
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHL, OP_SHR: begin
        if (w_count < CW'(2)) w_unf_d = 1'b1;
        else                  w_rep   = 1'b1;
      end
      OP_CLR: w_clr = 1'b1;
      OP_ACK: begin
        w_ovf_d = 1'b0;
        w_unf_d = 1'b0;
      end
      default: ;
    endcase
  end

  rpn_stack #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_replace2(w_rep),
    .i_clear   (w_clr),
    .i_data    (w_wdata),
    .o_top     (w_top),
    .o_next    (w_next),
    .o_count   (w_count),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign top     = w_top;
  assign next    = w_next;
  assign counter = w_count;
  assign ovf     = r_ovf;
  assign unf     = r_unf;

endmodule

// File: tb/tb_rpn_stack_calc.sv
// Self-checking bench for rpn_stack_calc: directed scenarios plus random ops against a queue model.
module tb_rpn_stack_calc;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic [3:0]       key = 4'hF;
  logic [WIDTH-1:0] val = '0;
  logic [WIDTH-1:0] top, next;
  logic [CW-1:0]    counter;
  logic             ovf, unf;

  int checks = 0;
  int failures = 0;

  logic [WIDTH-1:0] m_stk[$];
  bit               m_ovf, m_unf;

  rpn_stack_calc #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .mode   (mode),
    .key    (key),
    .val    (val),
    .top    (top),
    .next   (next),
    .counter(counter),
    .ovf    (ovf),
    .unf    (unf)
  );

  always #5 clk = ~clk;

  // Reference: apply one accepted key pattern using plain queue arithmetic.
  function automatic void model_apply(input logic [3:0] k, input logic [1:0] md,
                                      input logic [WIDTH-1:0] v);
    int idx;
    logic [WIDTH-1:0] t, n, r;
    idx = -1;
    for (int i = 3; i >= 0; i--) if (k[i] == 1'b0) idx = i;
    if (idx == 2) begin
      m_stk.delete();
    end else if (idx == 3) begin
      m_ovf = 0;
      m_unf = 0;
    end else if (idx >= 0 && md == 2'b00) begin
      if (idx == 0) begin
        if (m_stk.size() == DEPTH) m_ovf = 1;
        else m_stk.push_back(v);
      end else begin
        if (m_stk.size() == 0) m_unf = 1;
        else void'(m_stk.pop_back());
      end
    end else if (idx >= 0) begin
      if (m_stk.size() < 2) begin
        m_unf = 1;
      end else begin
        t = m_stk.pop_back();
        n = m_stk.pop_back();
        case ({md, idx[0]})
          3'b010:  r = n + t;
          3'b011:  r = n - t;
          3'b100:  r = n & t;
          3'b101:  r = n | t;
          3'b110:  r = (t >= WIDTH) ? '0 : WIDTH'(n << t);
          default: r = (t >= WIDTH) ? '0 : WIDTH'(n >> t);
        endcase
        m_stk.push_back(r);
      end
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    key = 4'hF;
    @(negedge clk);
    rst = 1'b0;
    m_stk.delete();
    m_ovf = 0;
    m_unf = 0;
  endtask

  // One press lasting one cycle, then release so the gate re-arms.
  task automatic press(input logic [3:0] k, input logic [1:0] md, input logic [WIDTH-1:0] v);
    @(negedge clk);
    key  = k;
    mode = md;
    val  = v;
    @(negedge clk);
    key = 4'hF;
    @(negedge clk);
    model_apply(k, md, v);
  endtask

  task automatic test_reset();
    do_reset();
    checks += 5;
    if (top !== 16'h0)   begin failures++; $display("FAIL reset_top got=%h exp=0", top); end
    if (next !== 16'h0)  begin failures++; $display("FAIL reset_next got=%h exp=0", next); end
    if (counter !== 4'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", counter); end
    if (ovf !== 1'b0)    begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    if (unf !== 1'b0)    begin failures++; $display("FAIL reset_unf got=%b exp=0", unf); end
  endtask

  task automatic test_push_add();
    do_reset();
    press(4'hE, 2'b00, 16'd3);
    press(4'hE, 2'b00, 16'd5);
    checks += 3;
    if (counter !== 4'd2) begin failures++; $display("FAIL push2_cnt got=%0d exp=2", counter); end
    if (top !== 16'd5)    begin failures++; $display("FAIL push2_top got=%0d exp=5", top); end
    if (next !== 16'd3)   begin failures++; $display("FAIL push2_next got=%0d exp=3", next); end
    press(4'hE, 2'b01, 16'd0);
    checks += 3;
    if (top !== 16'd8)    begin failures++; $display("FAIL add_top got=%0d exp=8", top); end
    if (next !== 16'd0)   begin failures++; $display("FAIL add_next got=%0d exp=0", next); end
    if (counter !== 4'd1) begin failures++; $display("FAIL add_cnt got=%0d exp=1", counter); end
  endtask

  task automatic test_sub_shift();
    do_reset();
    press(4'hE, 2'b00, 16'h0001);
    press(4'hE, 2'b00, 16'h0003);
    press(4'hD, 2'b01, 16'h0000);
    checks += 1;
    if (top !== 16'hFFFE) begin failures++; $display("FAIL sub_wrap got=%h exp=fffe", top); end
    press(4'hE, 2'b00, 16'h0010);
    press(4'hE, 2'b11, 16'h0000);
    checks += 2;
    if (top !== 16'h0)    begin failures++; $display("FAIL shl_wide got=%h exp=0", top); end
    if (counter !== 4'd1) begin failures++; $display("FAIL shl_cnt got=%0d exp=1", counter); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 9; i++) press(4'hE, 2'b00, WIDTH'(i));
    checks += 3;
    if (counter !== 4'd8) begin failures++; $display("FAIL ovf_cnt got=%0d exp=8", counter); end
    if (top !== 16'd8)    begin failures++; $display("FAIL ovf_top got=%0d exp=8", top); end
    if (ovf !== 1'b1)     begin failures++; $display("FAIL ovf_flag got=%b exp=1", ovf); end
    press(4'h7, 2'b00, 16'd0);
    checks += 3;
    if (ovf !== 1'b0)     begin failures++; $display("FAIL ack_ovf got=%b exp=0", ovf); end
    if (top !== 16'd8)    begin failures++; $display("FAIL ack_top got=%0d exp=8", top); end
    if (counter !== 4'd8) begin failures++; $display("FAIL ack_cnt got=%0d exp=8", counter); end
  endtask

  task automatic test_underflow();
    do_reset();
    press(4'hD, 2'b00, 16'd0);
    checks += 3;
    if (unf !== 1'b1)     begin failures++; $display("FAIL pop_unf got=%b exp=1", unf); end
    if (counter !== 4'd0) begin failures++; $display("FAIL pop_cnt got=%0d exp=0", counter); end
    if (top !== 16'd0)    begin failures++; $display("FAIL pop_top got=%0d exp=0", top); end
    press(4'h7, 2'b00, 16'd0);
    press(4'hE, 2'b00, 16'd42);
    press(4'hE, 2'b01, 16'd0);
    checks += 3;
    if (unf !== 1'b1)     begin failures++; $display("FAIL add1_unf got=%b exp=1", unf); end
    if (counter !== 4'd1) begin failures++; $display("FAIL add1_cnt got=%0d exp=1", counter); end
    if (top !== 16'd42)   begin failures++; $display("FAIL add1_top got=%0d exp=42", top); end
  endtask

  task automatic test_hold_gating();
    do_reset();
    @(negedge clk);
    key = 4'hE; mode = 2'b00; val = 16'd7;
    repeat (20) @(negedge clk);
    key = 4'hF;
    @(negedge clk);
    checks += 2;
    if (counter !== 4'd1) begin failures++; $display("FAIL hold_cnt got=%0d exp=1", counter); end
    if (top !== 16'd7)    begin failures++; $display("FAIL hold_top got=%0d exp=7", top); end
    press(4'hC, 2'b00, 16'd9);
    checks += 2;
    if (counter !== 4'd2) begin failures++; $display("FAIL simul_cnt got=%0d exp=2", counter); end
    if (top !== 16'd9)    begin failures++; $display("FAIL simul_top got=%0d exp=9", top); end
    @(negedge clk);
    key = 4'hE; val = 16'd11;
    @(negedge clk);
    key = 4'hC;
    @(negedge clk);
    key = 4'hF;
    @(negedge clk);
    checks += 2;
    if (counter !== 4'd3) begin failures++; $display("FAIL inhold_cnt got=%0d exp=3", counter); end
    if (top !== 16'd11)   begin failures++; $display("FAIL inhold_top got=%0d exp=11", top); end
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    press(4'hD, 2'b00, 16'd0);
    press(4'hE, 2'b00, 16'd4);
    press(4'hE, 2'b00, 16'd6);
    @(negedge clk);
    key = 4'hE; val = 16'd1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    key = 4'hF;
    checks += 5;
    if (top !== 16'h0)    begin failures++; $display("FAIL rsthold_top got=%h exp=0", top); end
    if (next !== 16'h0)   begin failures++; $display("FAIL rsthold_next got=%h exp=0", next); end
    if (counter !== 4'd0) begin failures++; $display("FAIL rsthold_cnt got=%0d exp=0", counter); end
    if (ovf !== 1'b0)     begin failures++; $display("FAIL rsthold_ovf got=%b exp=0", ovf); end
    if (unf !== 1'b0)     begin failures++; $display("FAIL rsthold_unf got=%b exp=0", unf); end
    m_stk.delete(); m_ovf = 0; m_unf = 0;
    press(4'hE, 2'b00, 16'd5);
    checks += 2;
    if (counter !== 4'd1) begin failures++; $display("FAIL repress_cnt got=%0d exp=1", counter); end
    if (top !== 16'd5)    begin failures++; $display("FAIL repress_top got=%0d exp=5", top); end
  endtask

  task automatic test_random();
    logic [3:0] mask;
    logic [WIDTH-1:0] v, e_top, e_next;
    int r;
    do_reset();
    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 19);
      if (r < 8)       mask = 4'h1;
      else if (r < 16) mask = 4'h2;
      else if (r < 18) mask = 4'($urandom_range(1, 15));
      else if (r == 18) mask = 4'h8;
      else             mask = 4'h4;
      v = ($urandom_range(0, 1) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 20));
      press(~mask, 2'($urandom_range(0, 3)), v);
      e_top  = (m_stk.size() > 0) ? m_stk[m_stk.size() - 1] : '0;
      e_next = (m_stk.size() > 1) ? m_stk[m_stk.size() - 2] : '0;
      checks += 5;
      if (top !== e_top) begin
        failures++; $display("FAIL rnd_top it=%0d got=%h exp=%h", it, top, e_top);
      end
      if (next !== e_next) begin
        failures++; $display("FAIL rnd_next it=%0d got=%h exp=%h", it, next, e_next);
      end
      if (counter !== CW'(m_stk.size())) begin
        failures++; $display("FAIL rnd_cnt it=%0d got=%0d exp=%0d", it, counter, m_stk.size());
      end
      if (ovf !== m_ovf) begin
        failures++; $display("FAIL rnd_ovf it=%0d got=%b exp=%b", it, ovf, m_ovf);
      end
      if (unf !== m_unf) begin
        failures++; $display("FAIL rnd_unf it=%0d got=%b exp=%b", it, unf, m_unf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_push_add();
    test_sub_shift();
    test_overflow();
    test_underflow();
    test_hold_gating();
    test_reset_mid_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
